// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one subtractor cell is stepped LSB first, one bit per clock.
// Optional macro SERIAL_SUB_SAT_EN clamps diff to 0 when the final borrow is 1.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q;

  logic a_bit, b_bit, d_bit, br_d, last_bit;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Subtractor cell for the bit currently selected by the counter
  always_comb begin
    a_bit = a_q[cnt_q];
    b_bit = b_q[cnt_q];
    d_bit = a_bit ^ b_bit ^ br_q;
    br_d  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_d = res_q;
    res_d[cnt_q] = d_bit;
  end

  always_comb begin
`ifdef SERIAL_SUB_SAT_EN
    diff_d = br_d ? '0 : res_d;
`else
    diff_d = res_d;
`endif
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SHIFT: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath; result registers only update on the final bit so SHIFT never exposes partials
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            res_q <= '0;
            cnt_q <= '0;
            br_q  <= 1'b0;
          end
        end
        SHIFT: begin
          res_q <= res_d;
          br_q  <= br_d;
          if (last_bit) begin
            diff_q   <= diff_d;
            borrow_q <= br_d;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          res_q <= res_q;
        end
      endcase
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8); define SERIAL_SUB_SAT_EN to match a saturating build.
module tb_serial_sub_ctrl;

  typedef struct {
    logic [7:0] d;
    logic       br;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] a, b, diff;
  logic       busy, done, borrow_out;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t m;
    logic [8:0] r;
    r    = {1'b0, x} - {1'b0, y};
    m.br = r[8];
    m.d  = r[7:0];
`ifdef SERIAL_SUB_SAT_EN
    if (m.br) m.d = 8'h00;
`endif
    return m;
  endfunction

  // Scoreboard: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got diff=%02h borrow=%0b, required no done pulse", diff, borrow_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (diff !== e.d || borrow_out !== e.br) begin
          errors++;
          $display("FAIL result: got diff=%02h borrow=%0b, required diff=%02h borrow=%0b",
                   diff, borrow_out, e.d, e.br);
        end else begin
          $display("txn diff=%02h borrow=%0b ok", diff, borrow_out);
        end
      end
    end
  end

  // Pulses start for one edge (edge k); returns during cycle k
  task automatic pulse_start(input logic [7:0] x, input logic [7:0] y, input bit push);
    @(posedge clk); #1;
    a = x; b = y; start = 1'b1;
    if (push) sb_q.push_back(model(x, y));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the cycle index (relative to cycle k) of the done pulse, -1 on timeout
  task automatic wait_done(output int j);
    j = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        j = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%0b done=%0b diff=%02h borrow=%0b, required all 0",
               busy, done, diff, borrow_out);
    end
  endtask

  task automatic test_basic;
    int j, busy_cnt;
    bit partial;
    j = -1; busy_cnt = 0; partial = 0;
    pulse_start(8'h05, 8'h03, 1);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        j = n;
        break;
      end
      if (diff !== 8'h00) partial = 1;
    end
    checks++;
    if (j != 8) begin
      errors++;
      $display("FAIL basic_latency: got done at cycle k+%0d, required k+8", j);
    end
    checks++;
    if (busy_cnt != 9) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, required 9", busy_cnt);
    end
    checks++;
    if (partial) begin
      errors++;
      $display("FAIL basic_no_partial: got diff changing during SHIFT, required stable 00");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_return_idle: got busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_vectors;
    logic [7:0] va[6] = '{8'h03, 8'h00, 8'hA5, 8'hFF, 8'h80, 8'h01};
    logic [7:0] vb[6] = '{8'h05, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h02};
    int j;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] x, y;
      if (i < 6) begin
        x = va[i]; y = vb[i];
      end else begin
        x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, 255));
      end
      pulse_start(x, y, 1);
      wait_done(j);
      checks++;
      if (j != 8) begin
        errors++;
        $display("FAIL vector_latency: a=%02h b=%02h got done at k+%0d, required k+8", x, y, j);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_busy_ignore;
    int ndone, done_at;
    ndone = 0; done_at = -1;
    pulse_start(8'h0F, 8'h40, 1);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; a = 8'h10; b = 8'h01;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
    end
    checks++;
    if (ndone != 1 || done_at != 5) begin
      errors++;
      $display("FAIL busy_ignore: got %0d done pulses first at k+%0d, required 1 at k+8", ndone, done_at + 3);
    end
  endtask

  task automatic test_reset_abort;
    bit saw_done;
    int j;
    saw_done = 0;
    pulse_start(8'h90, 8'h20, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%0b diff=%02h borrow=%0b done=%0b, required all 0",
               busy, diff, borrow_out, done);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done: got done pulse after reset, required none");
    end
    pulse_start(8'h22, 8'h11, 1);
    wait_done(j);
    checks++;
    if (j != 8) begin
      errors++;
      $display("FAIL abort_fresh_run: got done at k+%0d, required k+8", j);
    end
    // reset and start on the same edge: reset wins
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; a = 8'h44; b = 8'h11;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_same_edge: got busy=%0b, required 0", busy);
    end
    repeat (12) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    int d1, d2, nd;
    d1 = -1; d2 = -1; nd = 0;
    @(posedge clk); #1;
    a = 8'h77; b = 8'h22; start = 1'b1;
    sb_q.push_back(model(8'h77, 8'h22));
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34;
    sb_q.push_back(model(8'h12, 8'h34));
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (n == 10) start = 1'b0;
      if (done) begin
        nd++;
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
    end
    checks++;
    if (nd != 2 || d1 != 8 || d2 != 18) begin
      errors++;
      $display("FAIL back_to_back: got %0d dones at k+%0d,k+%0d, required 2 at k+8,k+18", nd, d1, d2);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    test_reset();
    test_basic();
    test_vectors();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend, unsigned.
REQ-006 b  input  WIDTH  subtrahend, unsigned.
REQ-007 busy  output  1  high in SHIFT and DONE states.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 diff  output  WIDTH  registered result a-b.
REQ-010 borrow_out  output  1  registered final borrow (1 when a<b).

Function
REQ-011 The block SHALL sequence one half/full-subtractor bit cell bit-serially, LSB first, one bit per clock.
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 at edge k SHALL latch a and b into internal operand registers, clear the bit counter and the borrow register, and go to SHIFT; start=0 keeps IDLE.
REQ-014 SHIFT: each edge k+1..k+WIDTH SHALL process bit i = counter: d_i = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); the counter increments by 1.
REQ-015 At edge k+WIDTH (last bit) the FSM SHALL enter DONE and diff/borrow_out SHALL load the completed result in the same edge.
REQ-016 DONE SHALL last exactly one cycle (done=1, busy=1), then return to IDLE unconditionally.
REQ-017 Latency: done SHALL be high during the cycle following edge k+WIDTH; the next start is accepted no earlier than edge k+WIDTH+2.
REQ-018 start while busy=1 SHALL be ignored, with no queuing.
REQ-019 Changes on a/b while busy=1 SHALL NOT affect the result in flight.
REQ-020 diff and borrow_out SHALL hold their value until the next completion or reset; they SHALL NOT show partial results during SHIFT.
REQ-021 The counter SHALL be sized to hold values 0..WIDTH-1 and SHALL NOT wrap within one operation.
REQ-022 WIDTH=1 SHALL behave as a registered half subtractor with done at k+1.

Reset
REQ-023 rst=1 at any edge SHALL force IDLE and clear counter, borrow register, operand registers, diff, borrow_out, done and busy to 0.
REQ-024 Reset during SHIFT or DONE SHALL abort the operation without producing a done pulse.
REQ-025 rst and start high on the same edge: reset SHALL win, and start SHALL be dropped.

Configuration
REQ-026 Macro SERIAL_SUB_SAT_EN: when defined, a final borrow of 1 SHALL load diff with 0 (unsigned saturation); borrow_out is still reported as 1.
REQ-027 When SERIAL_SUB_SAT_EN is undefined, diff SHALL be the modulo-2^WIDTH difference.

Verification (WIDTH=8)
REQ-028 After rst, with a=5, b=3 and start pulsed at edge k: done is high only after edge k+8, diff=0x02, borrow_out=0, busy is high for 9 cycles.
REQ-029 a=3, b=5: diff=0xFE and borrow_out=1 without SERIAL_SUB_SAT_EN; diff=0x00 and borrow_out=1 with it.
REQ-030 a=0x00, b=0xFF gives diff=0x01 and borrow_out=1; a=b=0xA5 gives diff=0x00 and borrow_out=0.
REQ-031 start re-pulsed at k+3 with a/b changed to 0x10/0x01: ignored, the original result is delivered, and exactly one done pulse occurs.
REQ-032 rst asserted at edge k+4: busy=0, diff=0 and borrow_out=0 next cycle; no done pulse; a fresh start then completes normally.
REQ-033 Back-to-back runs with start held high: the second operation begins at edge k+10, and each result is correct.
